uart_ex: RTL

Parametrised full-duplex UART, the next generation of the team's basic UART. It adds configurable parity and stop bits, a 16x-oversampled receiver with majority voting, and a one-word TX holding register behind a valid/ready handshake. It also adds an RX output register with parity, framing and overrun status. It sits between the host-link pins and the manycore's I/O bridge.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_baud_gen.sv | 26 ++
 rtl/uart_ex.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for uart_ex: parity modes, FSM state encodings and the
// parity helper used by the transmitter.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_e;

    typedef enum logic {
        TX_IDLE,
        TX_SHIFT
    } tx_state_e;

    // Callers zero-extend narrower words, so the unused upper bits add no ones.
    function automatic logic parity_bit(input logic [8:0] data, input int mode);
        return (mode == PARITY_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running divider producing a one-cycle os_tick every OS_CYCLES clocks;
// restart realigns the phase so the first tick lands OS_CYCLES clocks later.
module uart_baud_gen #(
    parameter int OS_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    output logic os_tick
);

    localparam int CW = (OS_CYCLES > 1) ? $clog2(OS_CYCLES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        os_tick = (cnt_q == CW'(OS_CYCLES - 1)) && !restart;
        cnt_d   = (restart || os_tick) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_ex.sv
// Full-duplex UART: TX holding register + frame shifter, RX 16x-oversampled
// receiver with majority vote and an output register carrying status flags.
module uart_ex
    import uart_pkg::*;
#(
    parameter int CLK_HZ    = 50000000,
    parameter int SCLK_HZ   = 115200,
    parameter int WIDTH     = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rxd,
    output logic             txd,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx_busy,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             rx_parity_err,
    output logic             rx_frame_err,
    output logic             rx_overrun
);

    localparam int BIT_CYCLES = CLK_HZ / SCLK_HZ;
    localparam int OS_CYCLES  = BIT_CYCLES / 16;
    localparam int HAS_PAR    = (PARITY != PARITY_NONE) ? 1 : 0;
    localparam int FRAME_BITS = 1 + WIDTH + HAS_PAR + STOP_BITS;
    localparam int BC_W       = $clog2(BIT_CYCLES);
    localparam int FB_W       = $clog2(FRAME_BITS);

    if (OS_CYCLES < 1) begin : g_err_os
        $error("uart_ex: CLK_HZ/SCLK_HZ must be at least 16");
    end
    if (WIDTH < 5 || WIDTH > 9) begin : g_err_width
        $error("uart_ex: WIDTH must be 5..9");
    end
    if (PARITY != PARITY_NONE && PARITY != PARITY_ODD && PARITY != PARITY_EVEN) begin : g_err_par
        $error("uart_ex: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_err_stop
        $error("uart_ex: STOP_BITS must be 1 or 2");
    end

    // ---------------- transmitter ----------------
    tx_state_e             tx_state_q, tx_state_d;
    logic [WIDTH-1:0]      hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic [FRAME_BITS-1:0] tx_shift_q, tx_shift_d, frame;
    logic [BC_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [FB_W-1:0]       bits_left_q, bits_left_d;
    logic                  txd_q, txd_d;
    logic                  tx_accept, tx_load;

    always_comb begin
        frame        = '1;
        frame[0]     = 1'b0;
        frame[WIDTH:1] = hold_q;
        if (HAS_PAR != 0) frame[WIDTH+1] = parity_bit(9'(hold_q), PARITY);
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        tx_state_d  = tx_state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        tx_shift_d  = tx_shift_q;
        bit_cnt_d   = bit_cnt_q;
        bits_left_d = bits_left_q;
        txd_d       = txd_q;
        tx_load     = 1'b0;
        tx_accept   = tx_valid && !hold_full_q;

        case (tx_state_q)
            TX_IDLE: tx_load = hold_full_q;
            TX_SHIFT: begin
                if (bit_cnt_q != '0) begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end else if (bits_left_q != '0) begin
                    txd_d       = tx_shift_q[0];
                    tx_shift_d  = tx_shift_q >> 1;
                    bits_left_d = bits_left_q - 1'b1;
                    bit_cnt_d   = BC_W'(BIT_CYCLES - 1);
                end else if (hold_full_q) begin
                    tx_load = 1'b1;
                end else begin
                    tx_state_d = TX_IDLE;
                    txd_d      = 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase

        // Reloading straight from the last stop bit leaves no idle gap.
        if (tx_load) begin
            tx_state_d  = TX_SHIFT;
            txd_d       = frame[0];
            tx_shift_d  = frame >> 1;
            bit_cnt_d   = BC_W'(BIT_CYCLES - 1);
            bits_left_d = FB_W'(FRAME_BITS - 1);
            hold_full_d = 1'b0;
        end
        if (tx_accept) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
    end

    assign txd      = txd_q;
    assign tx_ready = !hold_full_q;
    assign tx_busy  = (tx_state_q == TX_SHIFT) || hold_full_q;

    // ---------------- receiver ----------------
    logic [2:0]       sync_q, sync_d;
    logic             rxd_s, rx_fall;
    rx_state_e        rx_state_q, rx_state_d;
    logic [3:0]       tick_q, tick_d;
    logic [3:0]       rbit_q, rbit_d;
    logic [WIDTH-1:0] rshift_q, rshift_d;
    logic [1:0]       samp_q, samp_d;
    logic             rpar_err_q, rpar_err_d;
    logic             os_tick, restart, deliver, maj;

    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             rx_par_q, rx_par_d;
    logic             rx_frm_q, rx_frm_d;
    logic             rx_ovr_q, rx_ovr_d;
    logic             rx_accept;

    // sync_q[1] is the synchronised line, sync_q[2] its previous value.
    assign sync_d  = {sync_q[1:0], rxd};
    assign rxd_s   = sync_q[1];
    assign rx_fall = sync_q[2] && !sync_q[1];
    assign maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxd_s) | (samp_q[1] & rxd_s);

    uart_baud_gen #(.OS_CYCLES(OS_CYCLES)) u_baud (
        .clk     (clk),
        .reset_n (reset_n),
        .restart (restart),
        .os_tick (os_tick)
    );

    always_comb begin
        rx_state_d = rx_state_q;
        tick_d     = tick_q;
        rbit_d     = rbit_q;
        rshift_d   = rshift_q;
        samp_d     = samp_q;
        rpar_err_d = rpar_err_q;
        restart    = 1'b0;
        deliver    = 1'b0;

        case (rx_state_q)
            RX_IDLE: begin
                if (rx_fall) begin
                    restart    = 1'b1;
                    tick_d     = '0;
                    rpar_err_d = 1'b0;
                    rx_state_d = RX_START;
                end
            end
            RX_WAIT_HIGH: begin
                if (rxd_s) rx_state_d = RX_IDLE;
            end
            default: begin
                if (os_tick) begin
                    tick_d = tick_q + 4'd1;
                    if (tick_q == 4'd7) samp_d[0] = rxd_s;
                    if (tick_q == 4'd8) samp_d[1] = rxd_s;
                    if (tick_q == 4'd9) begin
                        case (rx_state_q)
                            RX_START: begin
                                rx_state_d = maj ? RX_IDLE : RX_DATA;
                                rbit_d     = '0;
                            end
                            RX_DATA: begin
                                rshift_d = {maj, rshift_q[WIDTH-1:1]};
                                rbit_d   = rbit_q + 4'd1;
                                if (rbit_q == 4'(WIDTH - 1))
                                    rx_state_d = (HAS_PAR != 0) ? RX_PARITY : RX_STOP;
                            end
                            RX_PARITY: begin
                                rpar_err_d = (^rshift_q ^ maj) != (PARITY == PARITY_ODD);
                                rx_state_d = RX_STOP;
                            end
                            RX_STOP: begin
                                deliver    = 1'b1;
                                rx_state_d = maj ? RX_IDLE : RX_WAIT_HIGH;
                            end
                            default: rx_state_d = RX_IDLE;
                        endcase
                    end
                end
            end
        endcase
    end

    always_comb begin
        rx_data_d = rx_data_q;
        rx_valid_d = rx_valid_q;
        rx_par_d  = rx_par_q;
        rx_frm_d  = rx_frm_q;
        rx_ovr_d  = rx_ovr_q;
        rx_accept = rx_valid_q && rx_ready;

        if (deliver && (!rx_valid_q || rx_ready)) begin
            rx_data_d  = rshift_q;
            rx_par_d   = rpar_err_q;
            rx_frm_d   = !maj;
            rx_valid_d = 1'b1;
        end else if (rx_accept) begin
            rx_valid_d = 1'b0;
        end

        if (deliver && rx_valid_q && !rx_ready) rx_ovr_d = 1'b1;
        else if (rx_accept)                     rx_ovr_d = 1'b0;
    end

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_parity_err = rx_par_q;
    assign rx_frame_err  = rx_frm_q;
    assign rx_overrun    = rx_ovr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_q  <= TX_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_shift_q  <= '1;
            bit_cnt_q   <= '0;
            bits_left_q <= '0;
            txd_q       <= 1'b1;
            sync_q      <= '1;
            rx_state_q  <= RX_IDLE;
            tick_q      <= '0;
            rbit_q      <= '0;
            rshift_q    <= '0;
            samp_q      <= '1;
            rpar_err_q  <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_par_q    <= 1'b0;
            rx_frm_q    <= 1'b0;
            rx_ovr_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples pre-edge values.
            tx_state_q  <= tx_state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_shift_q  <= tx_shift_d;
            bit_cnt_q   <= bit_cnt_d;
            bits_left_q <= bits_left_d;
            txd_q       <= txd_d;
            sync_q      <= sync_d;
            rx_state_q  <= rx_state_d;
            tick_q      <= tick_d;
            rbit_q      <= rbit_d;
            rshift_q    <= rshift_d;
            samp_q      <= samp_d;
            rpar_err_q  <= rpar_err_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_par_q    <= rx_par_d;
            rx_frm_q    <= rx_frm_d;
            rx_ovr_q    <= rx_ovr_d;
        end
    end

endmodule
